// File: rtl/llc_stats_if.sv
// rtl/llc_stats_if.sv - trace command and statistics bundle for the LLC stats model
//
// Purpose: carries one trace command per cycle into the cache model and the
// running statistic counters back out.
// Signals:
//   cmd_valid    command/address valid this cycle (master -> slave)
//   command      trace command code               (master -> slave)
//   address      byte address                     (master -> slave)
//   reads        CPU read request count           (slave -> master)
//   writes       CPU write request count          (slave -> master)
//   cache_hits   CPU requests that hit            (slave -> master)
//   cache_misses CPU requests that missed         (slave -> master)
interface llc_stats_if #(
  parameter int CMDSIZE   = 4,
  parameter int ADDR_BITS = 32,
  parameter int CNT_BITS  = 32
);
  logic                 cmd_valid;
  logic [CMDSIZE-1:0]   command;
  logic [ADDR_BITS-1:0] address;
  logic [CNT_BITS-1:0]  reads;
  logic [CNT_BITS-1:0]  writes;
  logic [CNT_BITS-1:0]  cache_hits;
  logic [CNT_BITS-1:0]  cache_misses;

  modport master (
    output cmd_valid, command, address,
    input  reads, writes, cache_hits, cache_misses
  );

  modport slave (
    input  cmd_valid, command, address,
    output reads, writes, cache_hits, cache_misses
  );
endinterface

// File: rtl/llc_stats_cache.sv
// rtl/llc_stats_cache.sv - behavioural last-level cache model with MESI, tree PLRU and statistics
//
// Purpose: processes one trace command per valid cycle, tracks tag/MESI per
// line and tree pseudo-LRU per set, and counts CPU reads, writes, hits, misses.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    llc_stats_if slave: cmd_valid/command/address in, counters out
module llc_stats_cache #(
  parameter int CMDSIZE     = 4,
  parameter int ADDR_BITS   = 32,
  parameter int OFFSET_BITS = 6,
  parameter int INDEX_BITS  = 14,
  parameter int WAYS        = 16,
  parameter int CNT_BITS    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  llc_stats_if.slave  bus
);
  localparam int TAG_BITS = ADDR_BITS - OFFSET_BITS - INDEX_BITS;
  localparam int SETS     = 1 << INDEX_BITS;
  localparam int WAY_BITS = $clog2(WAYS);

  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_S = 2'd1;
  localparam logic [1:0] ST_E = 2'd2;
  localparam logic [1:0] ST_M = 2'd3;

  localparam logic [CMDSIZE-1:0] CMD_RD_DATA = CMDSIZE'(0);
  localparam logic [CMDSIZE-1:0] CMD_WR_DATA = CMDSIZE'(1);
  localparam logic [CMDSIZE-1:0] CMD_RD_INST = CMDSIZE'(2);
  localparam logic [CMDSIZE-1:0] CMD_SNP_INV = CMDSIZE'(3);
  localparam logic [CMDSIZE-1:0] CMD_SNP_RD  = CMDSIZE'(4);
  localparam logic [CMDSIZE-1:0] CMD_SNP_RWM = CMDSIZE'(6);
  localparam logic [CMDSIZE-1:0] CMD_CLEAR   = CMDSIZE'(8);

  // Line storage has no reset. A per-set live bit stands in for "every line
  // Invalid and PLRU zero"; a set is read as all-zero until it is first
  // written, and the first write to a dead set writes its whole state row.
  logic [TAG_BITS-1:0]  tag_q   [SETS][WAYS];
  logic [WAYS-1:0][1:0] state_q [SETS];
  logic [WAYS-2:0]      plru_q  [SETS];

  logic [SETS-1:0]     set_live_q, set_live_d;
  logic [CNT_BITS-1:0] reads_q, reads_d;
  logic [CNT_BITS-1:0] writes_q, writes_d;
  logic [CNT_BITS-1:0] hits_q, hits_d;
  logic [CNT_BITS-1:0] misses_q, misses_d;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  live;
  logic [WAYS-1:0][1:0]  state_row;
  logic [WAYS-2:0]       plru_row;
  logic                  unused_offset;

  assign idx           = bus.address[OFFSET_BITS +: INDEX_BITS];
  assign tag           = bus.address[ADDR_BITS-1 -: TAG_BITS];
  assign live          = set_live_q[idx];
  assign state_row     = live ? state_q[idx] : '0;
  assign plru_row      = live ? plru_q[idx] : '0;
  assign unused_offset = ^bus.address[OFFSET_BITS-1:0];

  // Lookup: descending scan so the lowest-numbered way wins for the
  // first-Invalid search.
  logic                hit;
  logic [WAY_BITS-1:0] hit_way;
  logic                has_inv;
  logic [WAY_BITS-1:0] inv_way;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (state_row[w] == ST_I) begin
        has_inv = 1'b1;
        inv_way = WAY_BITS'(w);
      end else if (tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
  end

  // PLRU victim: walk from the root (heap order, children 2n+1 / 2n+2),
  // 0 goes left, 1 goes right; the path bits form the way number MSB first.
  logic [WAY_BITS-1:0] victim;

  always_comb begin
    logic [WAY_BITS-1:0] node;
    logic                dir;
    victim = '0;
    node   = '0;
    for (int l = 0; l < WAY_BITS; l++) begin
      dir    = plru_row[node];
      victim = (victim << 1) | WAY_BITS'(dir);
      node   = (node << 1) + WAY_BITS'(1) + WAY_BITS'(dir);
    end
  end

  logic [WAY_BITS-1:0] fill_way;
  logic [WAY_BITS-1:0] acc_way;

  assign fill_way = has_inv ? inv_way : victim;
  assign acc_way  = hit ? hit_way : fill_way;

  // PLRU update: every node on the path to acc_way is set to point away.
  logic [WAYS-2:0] plru_row_d;

  always_comb begin
    logic [WAY_BITS-1:0] node;
    logic [WAY_BITS-1:0] way_sh;
    logic                dir;
    plru_row_d = plru_row;
    node       = '0;
    way_sh     = acc_way;
    for (int l = 0; l < WAY_BITS; l++) begin
      dir              = way_sh[WAY_BITS-1];
      plru_row_d[node] = ~dir;
      node             = (node << 1) + WAY_BITS'(1) + WAY_BITS'(dir);
      way_sh           = way_sh << 1;
    end
  end

  logic                 row_we;
  logic                 tag_we;
  logic                 plru_we;
  logic [WAYS-1:0][1:0] state_row_d;

  always_comb begin
    set_live_d  = set_live_q;
    reads_d     = reads_q;
    writes_d    = writes_q;
    hits_d      = hits_q;
    misses_d    = misses_q;
    state_row_d = state_row;
    row_we      = 1'b0;
    tag_we      = 1'b0;
    plru_we     = 1'b0;
    if (bus.cmd_valid) begin
      case (bus.command)
        CMD_RD_DATA, CMD_RD_INST, CMD_WR_DATA: begin
          if (bus.command == CMD_WR_DATA) begin
            writes_d             = writes_q + CNT_BITS'(1);
            state_row_d[acc_way] = ST_M;
          end else begin
            reads_d = reads_q + CNT_BITS'(1);
            if (!hit) state_row_d[acc_way] = ST_E;
          end
          if (hit) begin
            hits_d = hits_q + CNT_BITS'(1);
          end else begin
            misses_d = misses_q + CNT_BITS'(1);
            tag_we   = 1'b1;
          end
          row_we          = 1'b1;
          plru_we         = 1'b1;
          set_live_d[idx] = 1'b1;
        end
        CMD_SNP_INV: begin
          if (hit && state_row[hit_way] == ST_S) begin
            state_row_d[hit_way] = ST_I;
            row_we               = 1'b1;
          end
        end
        CMD_SNP_RD: begin
          if (hit && (state_row[hit_way] == ST_M || state_row[hit_way] == ST_E)) begin
            state_row_d[hit_way] = ST_S;
            row_we               = 1'b1;
          end
        end
        CMD_SNP_RWM: begin
          if (hit) begin
            state_row_d[hit_way] = ST_I;
            row_we               = 1'b1;
          end
        end
        CMD_CLEAR: begin
          set_live_d = '0;
          reads_d    = '0;
          writes_d   = '0;
          hits_d     = '0;
          misses_d   = '0;
        end
        default: ;
      endcase
    end
  end

  // Writes landing during reset are harmless: the set is dead afterwards.
  always_ff @(posedge clk) begin
    if (row_we)  state_q[idx]         <= state_row_d;
    if (tag_we)  tag_q[idx][acc_way]  <= tag;
    if (plru_we) plru_q[idx]          <= plru_row_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_live_q <= '0;
      reads_q    <= '0;
      writes_q   <= '0;
      hits_q     <= '0;
      misses_q   <= '0;
    end else begin
      set_live_q <= set_live_d;
      reads_q    <= reads_d;
      writes_q   <= writes_d;
      hits_q     <= hits_d;
      misses_q   <= misses_d;
    end
  end

  assign bus.reads        = reads_q;
  assign bus.writes       = writes_q;
  assign bus.cache_hits   = hits_q;
  assign bus.cache_misses = misses_q;
endmodule

// File: tb/tb_llc_stats_cache.sv
// tb/tb_llc_stats_cache.sv - scoreboard bench for the LLC statistics cache model
module tb_llc_stats_cache;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  llc_stats_if bus ();

  llc_stats_cache dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rd;
    logic [31:0] wr;
    logic [31:0] hit;
    logic [31:0] miss;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] e_rd, e_wr, e_hit, e_miss;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic check_counts(input string pfx, input exp_t e);
    check_eq({pfx, "_reads"},  bus.reads,        e.rd);
    check_eq({pfx, "_writes"}, bus.writes,       e.wr);
    check_eq({pfx, "_hits"},   bus.cache_hits,   e.hit);
    check_eq({pfx, "_misses"}, bus.cache_misses, e.miss);
    check_eq({pfx, "_invariant"}, bus.reads + bus.writes, bus.cache_hits + bus.cache_misses);
  endtask

  // Expected counters come from the stimulus author's hit/miss annotation.
  task automatic send(input logic [3:0] cmd, input logic [31:0] addr, input bit exp_hit);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.command   = cmd;
    bus.address   = addr;
    if (cmd == 4'd0 || cmd == 4'd2 || cmd == 4'd1) begin
      if (cmd == 4'd1) e_wr++;
      else e_rd++;
      if (exp_hit) e_hit++;
      else e_miss++;
    end else if (cmd == 4'd8) begin
      e_rd = 0; e_wr = 0; e_hit = 0; e_miss = 0;
    end
    sb_q.push_back('{e_rd, e_wr, e_hit, e_miss});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
  endtask

  // Monitor: one expected snapshot per accepted command, checked after the edge.
  initial begin
    bit   v;
    exp_t e;
    forever begin
      @(posedge clk);
      v = bus.cmd_valid && rst_n;
      #1;
      if (v) begin
        check_eq("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check_counts("cmd", e);
        end
      end
    end
  end

  localparam logic [31:0] ADDR_A = 32'h1234_5680;
  localparam logic [31:0] ADDR_B = 32'h0ABC_D000;
  localparam logic [31:0] ADDR_C = 32'hFFFF_FFC0;

  initial begin
    exp_t zero;
    zero = '{32'd0, 32'd0, 32'd0, 32'd0};
    e_rd = 0; e_wr = 0; e_hit = 0; e_miss = 0;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.command   = '0;
    bus.address   = '0;
    #2;
    check_counts("reset", zero);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Read miss then hit on the same line.
    send(4'd0, 32'h0000_0040, 1'b0);
    send(4'd0, 32'h0000_0040, 1'b1);

    // Write-miss allocates Modified; snoop read -> Shared, snoop inval -> Invalid.
    send(4'd8, 32'h0, 1'b0);
    send(4'd1, 32'h1000_0000, 1'b0);
    send(4'd2, 32'h1000_0000, 1'b1);
    send(4'd4, 32'h1000_0000, 1'b0);
    send(4'd3, 32'h1000_0000, 1'b0);
    send(4'd0, 32'h1000_0000, 1'b0);
    send(4'd1, 32'h1000_0000, 1'b1);

    // Fill set 0 with 16 tags, a 17th evicts the first (way 0).
    send(4'd8, 32'h0, 1'b0);
    for (int t = 0; t < 16; t++) send(4'd0, 32'(t) << 20, 1'b0);
    send(4'd0, 32'd16 << 20, 1'b0);
    send(4'd0, 32'd0, 1'b0);
    // Re-fetch of tag 0 took way 8 (tag 8); tag 16 still sits in way 0.
    send(4'd0, 32'd16 << 20, 1'b1);
    send(4'd0, 32'd8 << 20, 1'b0);
    idle(2);

    // Snoop read-with-intent-to-modify invalidates.
    send(4'd8, 32'h0, 1'b0);
    send(4'd0, ADDR_A, 1'b0);
    send(4'd6, ADDR_A, 1'b0);
    send(4'd0, ADDR_A, 1'b0);

    // Exclusive -> Shared -> Invalid; snoop invalidate leaves Exclusive alone.
    send(4'd8, 32'h0, 1'b0);
    send(4'd0, ADDR_A, 1'b0);
    send(4'd4, ADDR_A, 1'b0);
    send(4'd3, ADDR_A, 1'b0);
    send(4'd0, ADDR_A, 1'b0);
    send(4'd0, ADDR_B, 1'b0);
    send(4'd3, ADDR_B, 1'b0);
    send(4'd5, ADDR_B, 1'b0);
    send(4'd4, ADDR_C, 1'b0);
    send(4'd0, ADDR_B, 1'b1);

    // Ignored codes and print do not allocate or count.
    send(4'd7,  ADDR_C, 1'b0);
    send(4'd12, ADDR_C, 1'b0);
    send(4'd15, ADDR_C, 1'b0);
    send(4'd9,  ADDR_C, 1'b0);
    send(4'd2,  ADDR_C, 1'b0);
    send(4'd1,  ADDR_C, 1'b1);
    idle(3);

    // Reset mid-stream, with a write presented in the same cycle.
    send(4'd1, ADDR_B, 1'b1);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.command   = 4'd1;
    bus.address   = 32'h0000_0080;
    rst_n         = 1'b0;
    #1;
    check_counts("async_rst", zero);
    @(posedge clk);
    #1;
    check_counts("rst_hold", zero);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.cmd_valid = 1'b0;
    e_rd = 0; e_wr = 0; e_hit = 0; e_miss = 0;
    send(4'd0, 32'h0000_0080, 1'b0);
    send(4'd0, ADDR_B, 1'b0);
    send(4'd0, 32'h0000_0080, 1'b1);
    idle(3);

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
